// File: rtl/ex_wb_skid_pkg.sv
// ex_wb_skid_pkg -- shared widths, buffer depth, occupancy encoding and the
// EX->WB entry record used by the skid buffer and its entry register.
package ex_wb_skid_pkg;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned DEST_W     = 3;
  localparam int unsigned FLAGS_W    = 6;   // CF/PF/AF/ZF/SF/OF
  localparam int unsigned DEPTH      = 2;
  localparam int unsigned SKIP_CNT_W = 16;

  typedef struct packed {
    logic [DATA_W-1:0]  res;
    logic [DEST_W-1:0]  dest;
    logic [FLAGS_W-1:0] flags;
    logic               reg_we;
    logic               mem_we;
    logic               flags_we;
    logic               skipped;
  } entry_t;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

endpackage

// File: rtl/ex_wb_skid_if.sv
// ex_wb_skid_if -- EX-side push, WB-side pop and flush signals of the skid
// buffer.
//   slave  : buffer view (accepts in_*, flush, out_ready; drives in_ready, out_*)
//   master : environment view (EX/WB/pipeline control)
interface ex_wb_skid_if;
  import ex_wb_skid_pkg::*;

  logic               in_valid;
  logic               in_ready;
  logic               in_skip;
  logic [DATA_W-1:0]  in_res;
  logic [DEST_W-1:0]  in_dest;
  logic [FLAGS_W-1:0] in_flags;
  logic               in_reg_we;
  logic               in_mem_we;
  logic               in_flags_we;
  logic               flush;
  logic               out_valid;
  logic               out_ready;
  logic [DATA_W-1:0]  out_res;
  logic [DEST_W-1:0]  out_dest;
  logic [FLAGS_W-1:0] out_flags;
  logic               out_reg_we;
  logic               out_mem_we;
  logic               out_flags_we;
  logic               out_skipped;

  modport slave (
    input  in_valid, in_skip, in_res, in_dest, in_flags,
           in_reg_we, in_mem_we, in_flags_we, flush, out_ready,
    output in_ready, out_valid, out_res, out_dest, out_flags,
           out_reg_we, out_mem_we, out_flags_we, out_skipped
  );

  modport master (
    output in_valid, in_skip, in_res, in_dest, in_flags,
           in_reg_we, in_mem_we, in_flags_we, flush, out_ready,
    input  in_ready, out_valid, out_res, out_dest, out_flags,
           out_reg_we, out_mem_we, out_flags_we, out_skipped
  );
endinterface

// File: rtl/ex_wb_entry.sv
// ex_wb_entry -- one buffer slot. Async active-low reset, synchronous clear,
// load with skip masking: a skipped op keeps res/dest/flags but has all write
// enables forced to 0 and skipped set.
//   clk, rst_n : clock, async active-low reset
//   i_clr      : synchronous clear (priority over i_load)
//   i_load     : capture i_d (masked when i_skip)
//   i_skip     : apply skip mask on this load
//   i_d / o_q  : entry in / stored entry
module ex_wb_entry
  import ex_wb_skid_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   i_clr,
  input  logic   i_load,
  input  logic   i_skip,
  input  entry_t i_d,
  output entry_t o_q
);

  entry_t r_q;
  entry_t w_masked;

  always_comb begin
    w_masked = i_d;
    if (i_skip) begin
      w_masked.reg_we   = 1'b0;
      w_masked.mem_we   = 1'b0;
      w_masked.flags_we = 1'b0;
      w_masked.skipped  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_q <= '0;
    else if (i_clr)  r_q <= '0;
    else if (i_load) r_q <= w_masked;
  end

  assign o_q = r_q;

endmodule

// File: rtl/ex_wb_skid.sv
// ex_wb_skid -- 2-entry in-order buffer between EX and WB.
//   clk      : clock, rising edge
//   clr      : async active-low reset
//   bus      : ex_wb_skid_if.slave (EX push, WB pop, flush)
//   skip_cnt : skipped-op counter, present only with SKIP_STATS_EN defined
// in_ready depends only on registered occupancy and flush, never on out_ready.
module ex_wb_skid
  import ex_wb_skid_pkg::*;
(
  input  logic             clk,
  input  logic             clr,
  ex_wb_skid_if.slave      bus
`ifdef SKIP_STATS_EN
  ,
  output logic [SKIP_CNT_W-1:0] skip_cnt
`endif
);

  occ_e   r_occ;
  occ_e   w_occ_nxt;
  logic   w_push;
  logic   w_pop;
  logic   w_ready;
  logic   w_valid;
  entry_t w_new;
  entry_t w_head;
  entry_t w_tail;
  entry_t w_head_d;
  entry_t w_out;
  logic   w_head_load, w_head_clr, w_head_skip;
  logic   w_tail_load, w_tail_clr;

  assign w_ready = (32'(r_occ) < DEPTH) && !bus.flush;
  assign w_valid = (r_occ != OCC_EMPTY);
  assign w_push  = bus.in_valid && w_ready;
  assign w_pop   = w_valid && bus.out_ready && !bus.flush;

  assign w_new = '{res:      bus.in_res,
                   dest:     bus.in_dest,
                   flags:    bus.in_flags,
                   reg_we:   bus.in_reg_we,
                   mem_we:   bus.in_mem_we,
                   flags_we: bus.in_flags_we,
                   skipped:  1'b0};

  // Slot 0 is always the head. Slots are cleared whenever they become empty
  // so an empty buffer presents all-zero payload and enables.
  always_comb begin
    w_occ_nxt   = r_occ;
    w_head_load = 1'b0;
    w_head_clr  = 1'b0;
    w_head_d    = w_new;
    w_head_skip = bus.in_skip;
    w_tail_load = 1'b0;
    w_tail_clr  = 1'b0;
    if (bus.flush) begin
      w_head_clr = 1'b1;
      w_tail_clr = 1'b1;
      w_occ_nxt  = OCC_EMPTY;
    end else begin
      case (r_occ)
        OCC_EMPTY: begin
          if (w_push) begin
            w_head_load = 1'b1;
            w_occ_nxt   = OCC_ONE;
          end
        end
        OCC_ONE: begin
          if (w_push && w_pop) begin
            w_head_load = 1'b1;
          end else if (w_push) begin
            w_tail_load = 1'b1;
            w_occ_nxt   = OCC_FULL;
          end else if (w_pop) begin
            w_head_clr = 1'b1;
            w_occ_nxt  = OCC_EMPTY;
          end
        end
        OCC_FULL: begin
          // Tail shifts into head; it is already masked, re-applying its own
          // skipped bit as the mask leaves it unchanged.
          if (w_pop) begin
            w_head_load = 1'b1;
            w_head_d    = w_tail;
            w_head_skip = w_tail.skipped;
            w_tail_clr  = 1'b1;
            w_occ_nxt   = OCC_ONE;
          end
        end
        default: w_occ_nxt = OCC_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) r_occ <= OCC_EMPTY;
    else      r_occ <= w_occ_nxt;
  end

  ex_wb_entry u_head (
    .clk    (clk),
    .rst_n  (clr),
    .i_clr  (w_head_clr),
    .i_load (w_head_load),
    .i_skip (w_head_skip),
    .i_d    (w_head_d),
    .o_q    (w_head)
  );

  ex_wb_entry u_tail (
    .clk    (clk),
    .rst_n  (clr),
    .i_clr  (w_tail_clr),
    .i_load (w_tail_load),
    .i_skip (bus.in_skip),
    .i_d    (w_new),
    .o_q    (w_tail)
  );

  assign w_out = w_valid ? w_head : '0;

  assign bus.in_ready     = w_ready;
  assign bus.out_valid    = w_valid;
  assign bus.out_res      = w_out.res;
  assign bus.out_dest     = w_out.dest;
  assign bus.out_flags    = w_out.flags;
  assign bus.out_reg_we   = w_out.reg_we;
  assign bus.out_mem_we   = w_out.mem_we;
  assign bus.out_flags_we = w_out.flags_we;
  assign bus.out_skipped  = w_out.skipped;

`ifdef SKIP_STATS_EN
  logic [SKIP_CNT_W-1:0] r_skip_cnt;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr)
      r_skip_cnt <= '0;
    else if (w_push && bus.in_skip && (r_skip_cnt != '1))
      r_skip_cnt <= r_skip_cnt + 1'b1;
  end

  assign skip_cnt = r_skip_cnt;
`endif

endmodule
